// File: rtl/ws2812_tx.sv
// WS2812 strip transmitter: pulls one colour per LED over a nxt/trig/t_valid handshake and sends it GRB, MSB first.
// Build option WS2812_BRIGHTNESS_EN scales each captured channel by (brightness+1)/256.
module ws2812_tx #(
   parameter int NUM_LEDS = 28,
   parameter int CLK_HZ   = 100000000,
   parameter int T0H_NS   = 400,
   parameter int T1H_NS   = 800,
   parameter int BIT_NS   = 1250,
   parameter int RESET_US = 280
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] avg_rgb,
   input  logic        trig,
   input  logic [7:0]  brightness,
   output logic        nxt,
   output logic        t_valid,
   output logic        rdy,
   output logic        dout,
   output logic        underrun
);

   localparam longint T0H_CYC   = (longint'(CLK_HZ) * longint'(T0H_NS)) / 64'sd1000000000;
   localparam longint T1H_CYC   = (longint'(CLK_HZ) * longint'(T1H_NS)) / 64'sd1000000000;
   localparam longint BIT_CYC   = (longint'(CLK_HZ) * longint'(BIT_NS)) / 64'sd1000000000;
   localparam longint RESET_CYC = (longint'(CLK_HZ) * longint'(RESET_US)) / 64'sd1000000;
   localparam longint MAX_CYC   = (RESET_CYC > BIT_CYC) ? RESET_CYC : BIT_CYC;
   localparam int     TW        = $clog2(MAX_CYC + 64'sd1);

   // Timer compare values are the last cycle index of each phase
   localparam logic [TW-1:0] T0H_LAST   = TW'(T0H_CYC - 64'sd1);
   localparam logic [TW-1:0] T1H_LAST   = TW'(T1H_CYC - 64'sd1);
   localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_CYC - 64'sd1);
   localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYC - 64'sd1);
   localparam logic [TW-1:0] T_ZERO     = {TW{1'b0}};
   localparam logic [TW-1:0] T_ONE      = {{(TW-1){1'b0}}, 1'b1};
   localparam logic [7:0]    NUM_C      = 8'(NUM_LEDS);

   localparam logic [1:0] HS_REQ  = 2'd0;
   localparam logic [1:0] HS_ACK  = 2'd1;
   localparam logic [1:0] HS_FULL = 2'd2;

   localparam logic [2:0] SR_IDLE  = 3'd0;
   localparam logic [2:0] SR_LOAD  = 3'd1;
   localparam logic [2:0] SR_HIGH  = 3'd2;
   localparam logic [2:0] SR_LOW   = 3'd3;
   localparam logic [2:0] SR_LATCH = 3'd4;

   logic          trig_meta_r, trig_s;
   logic [1:0]    hs_state_r, hs_state_n;
   logic [2:0]    ser_state_r, ser_state_n;
   logic [23:0]   hold_r, hold_n;
   logic          hold_valid_r, hold_valid_n;
   logic [7:0]    acc_cnt_r, acc_cnt_n;
   logic [7:0]    tx_cnt_r, tx_cnt_n;
   logic [23:0]   shift_r, shift_n;
   logic [4:0]    bit_idx_r, bit_idx_n;
   logic [TW-1:0] timer_r, timer_n;
   logic          gap_r, gap_n;
   logic          t_valid_n, nxt_n, rdy_n, dout_n, underrun_n;
   logic          cap_s, clr_cnt_s;
   logic [23:0]   cap_rgb_s;

`ifdef WS2812_BRIGHTNESS_EN
   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] p;
      p = {8'd0, c} * ({8'd0, b} + 16'd1);
      return p[15:8];
   endfunction

   assign cap_rgb_s = {scale_ch(avg_rgb[23:16], brightness),
                       scale_ch(avg_rgb[15:8],  brightness),
                       scale_ch(avg_rgb[7:0],   brightness)};
`else
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign cap_rgb_s = avg_rgb;
`endif

   // Next-state logic for both the handshake and the serializer
   always_comb begin
      hs_state_n   = hs_state_r;
      ser_state_n  = ser_state_r;
      hold_n       = hold_r;
      hold_valid_n = hold_valid_r;
      acc_cnt_n    = acc_cnt_r;
      tx_cnt_n     = tx_cnt_r;
      shift_n      = shift_r;
      bit_idx_n    = bit_idx_r;
      timer_n      = timer_r;
      gap_n        = gap_r;
      t_valid_n    = t_valid;
      underrun_n   = 1'b0;
      cap_s        = 1'b0;
      clr_cnt_s    = 1'b0;

      case (ser_state_r)
         SR_IDLE: begin
            if (hold_valid_r) ser_state_n = SR_LOAD;
            else              ser_state_n = SR_IDLE;
         end
         SR_LOAD: begin
            shift_n      = {hold_r[15:8], hold_r[23:16], hold_r[7:0]};
            hold_valid_n = 1'b0;
            bit_idx_n    = 5'd23;
            timer_n      = T_ZERO;
            gap_n        = 1'b0;
            ser_state_n  = SR_HIGH;
         end
         SR_HIGH: begin
            timer_n = timer_r + T_ONE;
            if (timer_r == (shift_r[23] ? T1H_LAST : T0H_LAST)) ser_state_n = SR_LOW;
            else                                                 ser_state_n = SR_HIGH;
         end
         SR_LOW: begin
            // A gap parks the timer at the end of the last bit until the hold fills
            if (gap_r) begin
               if (hold_valid_r) ser_state_n = SR_LOAD;
               else              ser_state_n = SR_LOW;
            end else if (timer_r != BIT_LAST) begin
               timer_n = timer_r + T_ONE;
            end else if (bit_idx_r != 5'd0) begin
               shift_n     = {shift_r[22:0], 1'b0};
               bit_idx_n   = bit_idx_r - 5'd1;
               timer_n     = T_ZERO;
               ser_state_n = SR_HIGH;
            end else begin
               tx_cnt_n = tx_cnt_r + 8'd1;
               if (tx_cnt_r + 8'd1 == NUM_C) begin
                  timer_n     = T_ZERO;
                  ser_state_n = SR_LATCH;
               end else if (hold_valid_r) begin
                  ser_state_n = SR_LOAD;
               end else begin
                  gap_n      = 1'b1;
                  underrun_n = 1'b1;
               end
            end
         end
         SR_LATCH: begin
            if (timer_r == RESET_LAST) begin
               clr_cnt_s   = 1'b1;
               tx_cnt_n    = 8'd0;
               timer_n     = T_ZERO;
               ser_state_n = SR_IDLE;
            end else begin
               timer_n = timer_r + T_ONE;
            end
         end
         default: begin
            timer_n     = T_ZERO;
            ser_state_n = SR_LATCH;
         end
      endcase

      case (hs_state_r)
         HS_REQ: begin
            if (nxt && trig_s) begin
               cap_s        = 1'b1;
               hold_n       = cap_rgb_s;
               hold_valid_n = 1'b1;
               t_valid_n    = 1'b1;
               hs_state_n   = HS_ACK;
            end else begin
               hs_state_n = HS_REQ;
            end
         end
         HS_ACK: begin
            if (!trig_s) begin
               t_valid_n  = 1'b0;
               hs_state_n = HS_FULL;
            end else begin
               hs_state_n = HS_ACK;
            end
         end
         HS_FULL: begin
            // The serializer may already have taken the pixel while we sat in ACK
            if (!hold_valid_r || ser_state_r == SR_LOAD) hs_state_n = HS_REQ;
            else                                          hs_state_n = HS_FULL;
         end
         default: begin
            t_valid_n  = 1'b0;
            hs_state_n = HS_REQ;
         end
      endcase

      if (clr_cnt_s) acc_cnt_n = {7'd0, cap_s};
      else           acc_cnt_n = acc_cnt_r + {7'd0, cap_s};

      nxt_n  = (hs_state_n == HS_REQ) && !hold_valid_n && (acc_cnt_n < NUM_C);
      rdy_n  = (ser_state_n == SR_IDLE) && (acc_cnt_n == 8'd0) && !hold_valid_n;
      dout_n = (ser_state_n == SR_HIGH);
   end

   // State, trig synchroniser and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_meta_r  <= 1'b0;
         trig_s       <= 1'b0;
         hs_state_r   <= HS_REQ;
         ser_state_r  <= SR_LATCH;
         hold_r       <= 24'd0;
         hold_valid_r <= 1'b0;
         acc_cnt_r    <= 8'd0;
         tx_cnt_r     <= 8'd0;
         shift_r      <= 24'd0;
         bit_idx_r    <= 5'd0;
         timer_r      <= T_ZERO;
         gap_r        <= 1'b0;
         nxt          <= 1'b0;
         t_valid      <= 1'b0;
         rdy          <= 1'b0;
         dout         <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         trig_meta_r  <= trig;
         trig_s       <= trig_meta_r;
         hs_state_r   <= hs_state_n;
         ser_state_r  <= ser_state_n;
         hold_r       <= hold_n;
         hold_valid_r <= hold_valid_n;
         acc_cnt_r    <= acc_cnt_n;
         tx_cnt_r     <= tx_cnt_n;
         shift_r      <= shift_n;
         bit_idx_r    <= bit_idx_n;
         timer_r      <= timer_n;
         gap_r        <= gap_n;
         nxt          <= nxt_n;
         t_valid      <= t_valid_n;
         rdy          <= rdy_n;
         dout         <= dout_n;
         underrun     <= underrun_n;
      end
   end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx with NUM_LEDS=3 and a shortened 2000-cycle latch.
// Expected GRB words for the brightness frame follow WS2812_BRIGHTNESS_EN.
module tb_ws2812_tx;

   localparam int NLED    = 3;
   localparam int RST_CYC = 2000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] avg_rgb = 24'd0;
   logic        trig = 1'b0;
   logic [7:0]  brightness = 8'hFF;
   logic        nxt, t_valid, rdy, dout, underrun;

   int n_chk  = 0;
   int n_fail = 0;

   int   hi_q[$];
   int   per_q[$];
   int   hi_cnt = 0, since_rise = 0, low_run = 0, nt_viol = 0, und_cnt = 0;
   logic dout_d = 1'b0;

   ws2812_tx #(.NUM_LEDS(NLED), .CLK_HZ(100000000), .T0H_NS(400), .T1H_NS(800),
               .BIT_NS(1250), .RESET_US(20)) dut (
      .clk(clk), .rst(rst), .avg_rgb(avg_rgb), .trig(trig), .brightness(brightness),
      .nxt(nxt), .t_valid(t_valid), .rdy(rdy), .dout(dout), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Line monitor: high-pulse widths, intra-frame rise-to-rise periods, low run length
   always @(negedge clk) begin
      since_rise = since_rise + 1;
      if (dout && !dout_d) begin
         if (since_rise <= 200) per_q.push_back(since_rise);
         since_rise = 0;
      end
      if (dout) begin
         hi_cnt  = hi_cnt + 1;
         low_run = 0;
      end else begin
         if (dout_d) begin
            hi_q.push_back(hi_cnt);
            hi_cnt = 0;
         end
         low_run = low_run + 1;
      end
      if (nxt && t_valid) nt_viol = nt_viol + 1;
      if (underrun) und_cnt = und_cnt + 1;
      dout_d = dout;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit cond(input int which, input int arg);
      case (which)
         0:       return nxt === 1'b1;
         1:       return underrun === 1'b1;
         default: return hi_q.size() >= arg;
      endcase
   endfunction

   task automatic wait_cond(input int which, input int arg, input int bound, input string tag);
      int k;
      k = 0;
      while (!cond(which, arg) && k < bound) begin
         tick();
         k++;
      end
      check({tag, " wait"}, 32'(cond(which, arg)), 32'd1);
   endtask

   task automatic send_pixel(input logic [23:0] c, input bit chk_lat, input string tag);
      wait_cond(0, 0, 20000, {tag, " nxt"});
      avg_rgb = c;
      trig    = 1'b1;
      tick();
      tick();
      check({tag, " tv_early"}, 32'(t_valid), 32'd0);
      tick();
      check({tag, " tv_rise"}, 32'(t_valid), 32'd1);
      check({tag, " nxt_low"}, 32'(nxt), 32'd0);
      if (chk_lat) check({tag, " rdy_drop"}, 32'(rdy), 32'd0);
      trig = 1'b0;
      tick();
      if (chk_lat) check({tag, " load_low"}, 32'(dout), 32'd0);
      tick();
      if (chk_lat) check({tag, " dout_rise"}, 32'(dout), 32'd1);
      check({tag, " tv_hold"}, 32'(t_valid), 32'd1);
      tick();
      check({tag, " tv_fall"}, 32'(t_valid), 32'd0);
   endtask

   task automatic frame_end(input int low_exp, input string tag);
      int k, nseen;
      k = 0;
      nseen = 0;
      while (!rdy && k < 40000) begin
         if (nxt) nseen++;
         tick();
         k++;
      end
      check({tag, " rdy"}, 32'(rdy), 32'd1);
      check({tag, " latch_low"}, 32'(low_run), 32'(low_exp));
      check({tag, " no_extra_nxt"}, 32'(nseen), 32'd0);
      check({tag, " nxt_at_rdy"}, 32'(nxt), 32'd1);
   endtask

   task automatic frame_check(input int hb, input int pb, input logic [23:0] e0,
                              input logic [23:0] e1, input logic [23:0] e2,
                              input int n126, input int nper, input string tag);
      logic [23:0] exp_w [3];
      logic [23:0] w;
      int bad, c125, c126;
      exp_w[0] = e0;
      exp_w[1] = e1;
      exp_w[2] = e2;
      check({tag, " pulses"}, 32'(hi_q.size() - hb), 32'd72);
      bad = 0;
      for (int p = 0; p < 3; p++) begin
         w = 24'd0;
         for (int b = 0; b < 24; b++) begin
            w = {w[22:0], hi_q[hb + p * 24 + b] >= 60};
            if (hi_q[hb + p * 24 + b] != 40 && hi_q[hb + p * 24 + b] != 80) bad++;
         end
         check($sformatf("%s word%0d", tag, p), {8'd0, w}, {8'd0, exp_w[p]});
      end
      check({tag, " pulse_width"}, 32'(bad), 32'd0);
      c125 = 0;
      c126 = 0;
      for (int i = pb; i < per_q.size(); i++) begin
         if (per_q[i] == 125) c125++;
         if (per_q[i] == 126) c126++;
      end
      check({tag, " periods"}, 32'(per_q.size() - pb), 32'(nper));
      check({tag, " period126"}, 32'(c126), 32'(n126));
      check({tag, " period125"}, 32'(c125), 32'(nper - n126));
   endtask

   initial begin
      int hb, pb, hs;
      logic [23:0] exp_b0, exp_b2;

      // Reset state and the power-up latch
      repeat (4) tick();
      check("rst nxt", 32'(nxt), 32'd0);
      check("rst t_valid", 32'(t_valid), 32'd0);
      check("rst rdy", 32'(rdy), 32'd0);
      check("rst dout", 32'(dout), 32'd0);
      check("rst underrun", 32'(underrun), 32'd0);
      rst = 1'b0;
      repeat (RST_CYC - 1) tick();
      check("boot rdy_low", 32'(rdy), 32'd0);
      check("boot no_pulse", 32'(hi_q.size()), 32'd0);
      tick();
      check("boot rdy_high", 32'(rdy), 32'd1);
      check("boot nxt", 32'(nxt), 32'd1);

      // Frame 1: back-to-back pixels
      hb = hi_q.size();
      pb = per_q.size();
      send_pixel(24'hFF0000, 1'b1, "f1p0");
      send_pixel(24'h00FF00, 1'b0, "f1p1");
      send_pixel(24'h0000AA, 1'b0, "f1p2");
      frame_end(2085, "f1");
      frame_check(hb, pb, 24'h00FF00, 24'hFF0000, 24'h0000AA, 2, 71, "f1");

      // Frame 2: second pixel arrives late
      hb = hi_q.size();
      pb = per_q.size();
      send_pixel(24'h5A3C81, 1'b0, "f2p0");
      wait_cond(1, 0, 10000, "f2 underrun");
      check("f2 gap_start_low", 32'(low_run), 32'd45);
      repeat (1000) tick();
      check("f2 gap_dout", 32'(dout), 32'd0);
      check("f2 gap_low", 32'(low_run), 32'd1045);
      send_pixel(24'hA50F33, 1'b1, "f2p1");
      send_pixel(24'hFFFFFF, 1'b0, "f2p2");
      frame_end(2045, "f2");
      frame_check(hb, pb, 24'h3C5A81, 24'h0FA533, 24'hFFFFFF, 1, 70, "f2");
      check("f2 underrun_count", 32'(und_cnt), 32'd1);

      // Frame 3: one-cycle reset in the middle of pixel 1
      hb = hi_q.size();
      send_pixel(24'h123456, 1'b0, "f3p0");
      send_pixel(24'h654321, 1'b0, "f3p1");
      wait_cond(2, hb + 29, 10000, "f3 mid_pixel1");
      rst = 1'b1;
      tick();
      check("f3 rst dout", 32'(dout), 32'd0);
      check("f3 rst rdy", 32'(rdy), 32'd0);
      check("f3 rst nxt", 32'(nxt), 32'd0);
      check("f3 rst t_valid", 32'(t_valid), 32'd0);
      rst = 1'b0;
      tick();
      hs = hi_q.size();
      repeat (RST_CYC - 2) tick();
      check("f3 latch rdy_low", 32'(rdy), 32'd0);
      check("f3 latch no_pulse", 32'(hi_q.size()), 32'(hs));
      tick();
      check("f3 latch rdy_high", 32'(rdy), 32'd1);

      // Frame 4: restart from pixel 0 with brightness 127
`ifdef WS2812_BRIGHTNESS_EN
      exp_b0 = 24'h7F6408;
      exp_b2 = 24'h004001;
`else
      exp_b0 = 24'hFFC810;
      exp_b2 = 24'h008003;
`endif
      brightness = 8'd127;
      hb = hi_q.size();
      pb = per_q.size();
      send_pixel(24'hC8FF10, 1'b1, "f4p0");
      send_pixel(24'h000000, 1'b0, "f4p1");
      send_pixel(24'h800003, 1'b0, "f4p2");
      frame_end(2045, "f4");
      frame_check(hb, pb, exp_b0, 24'h000000, exp_b2, 2, 71, "f4");

      check("nxt_with_t_valid", 32'(nt_viol), 32'd0);
      check("underrun_total", 32'(und_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
